alu_exec_unit: RTL and testbench

- Parametrised successor to the single-cycle ALU control decode for the MIPS-lite datapath.
- Combines ALU-control decode (aluop/funct/opcode) with a registered execute stage and an iterative multiplier that writes HI/LO.
- Sits in the EX stage of the multicycle datapath. The controller stalls on busy and advances on done.

---
 rtl/alu_exec_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// MIPS-lite EX stage: ALU-control decode, registered single-cycle ALU and a
// shift-add multiplier that writes HI/LO. Optional overflow flag: ALU_OVF_EN.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic             ovf,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_NOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_MFHI  = 4'd6,
        OP_MFLO  = 4'd7,
        OP_MULT  = 4'd8,
        OP_MULTU = 4'd9,
        OP_ILL   = 4'd10
    } op_t;

    localparam int MSB = WIDTH - 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    op_t                op_s;
    logic [WIDTH-1:0]   alu_res_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     step_sum_s;
    logic [2*WIDTH-1:0] step_p_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               is_mul_s;
    logic               is_signed_mul_s;

`ifdef ALU_OVF_EN
    logic ovf_q, ovf_d;
    logic ovf_calc_s;
`endif

    // ALU-control decode of aluop/funct/opcode into an internal operation
    always_comb begin
        op_s = OP_ILL;
        case (aluop)
            2'b00: op_s = OP_ADD;
            2'b01: op_s = OP_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: op_s = OP_ADD;
                    6'b100010: op_s = OP_SUB;
                    6'b100100: op_s = OP_AND;
                    6'b100101: op_s = OP_OR;
                    6'b100111: op_s = OP_NOR;
                    6'b101010: op_s = OP_SLT;
                    6'b010000: op_s = OP_MFHI;
                    6'b010010: op_s = OP_MFLO;
                    6'b011000: op_s = OP_MULT;
                    6'b011001: op_s = OP_MULTU;
                    default:   op_s = OP_ILL;
                endcase
            end
            2'b11: begin
                case (opcode)
                    6'b001000: op_s = OP_ADD;
                    6'b001100: op_s = OP_AND;
                    6'b001101: op_s = OP_OR;
                    6'b001010: op_s = OP_SLT;
                    default:   op_s = OP_ILL;
                endcase
            end
            default: op_s = OP_ILL;
        endcase
    end

    // Single-cycle ALU datapath and multiplier operand/step arithmetic
    always_comb begin
        sum_s           = a + b;
        diff_s          = a - b;
        is_mul_s        = (op_s == OP_MULT) || (op_s == OP_MULTU);
        is_signed_mul_s = (op_s == OP_MULT);
        alu_res_s       = {WIDTH{1'b0}};
        case (op_s)
            OP_ADD:  alu_res_s = sum_s;
            OP_SUB:  alu_res_s = diff_s;
            OP_AND:  alu_res_s = a & b;
            OP_OR:   alu_res_s = a | b;
            OP_NOR:  alu_res_s = ~(a | b);
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: alu_res_s = hi_q;
            OP_MFLO: alu_res_s = lo_q;
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
        // magnitude of the most-negative value still fits as an unsigned WIDTH-bit number
        a_mag_s    = (is_signed_mul_s && a[MSB]) ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
        b_mag_s    = (is_signed_mul_s && b[MSB]) ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
        step_sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        step_p_s   = {step_sum_s, p_q[WIDTH-1:1]};
        prod_s     = neg_q ? (~p_q + {{(2*WIDTH-1){1'b0}}, 1'b1}) : p_q;
    end

`ifdef ALU_OVF_EN
    // Signed overflow: operands agree in sign (b inverted for sub) but result does not
    always_comb begin
        ovf_calc_s = 1'b0;
        case (op_s)
            OP_ADD:  ovf_calc_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
            OP_SUB:  ovf_calc_s = (a[MSB] == ~b[MSB]) && (diff_s[MSB] != a[MSB]);
            default: ovf_calc_s = 1'b0;
        endcase
    end
`endif

    // Next-state and registered-output logic for the IDLE/MUL/FIN controller
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = illegal_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        p_d       = p_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
`ifdef ALU_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && is_mul_s) begin
                    mcand_d = b_mag_s;
                    p_d     = {{WIDTH{1'b0}}, a_mag_s};
                    neg_d   = is_signed_mul_s && (a[MSB] ^ b[MSB]);
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end else if (start) begin
                    result_d  = alu_res_s;
                    zero_d    = (alu_res_s == {WIDTH{1'b0}});
                    illegal_d = (op_s == OP_ILL);
                    done_d    = 1'b1;
`ifdef ALU_OVF_EN
                    ovf_d     = ovf_calc_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                p_d   = step_p_s;
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_FIN: begin
                hi_d    = prod_s[2*WIDTH-1:WIDTH];
                lo_d    = prod_s[WIDTH-1:0];
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= {WIDTH{1'b0}};
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            p_q       <= {(2*WIDTH){1'b0}};
            neg_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ALU_OVF_EN
    // Overflow flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32); honours ALU_OVF_EN.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        ovf;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .aluop(aluop),
        .funct(funct), .opcode(opcode), .a(a), .b(b),
        .result(result), .zero(zero), .busy(busy), .done(done),
        .illegal(illegal), .ovf(ovf), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] op, input logic [5:0] f, input logic [5:0] o,
                          input logic [31:0] aa, input logic [31:0] bb);
        aluop  = op;
        funct  = f;
        opcode = o;
        a      = aa;
        b      = bb;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [5:0] o,
                         input logic [31:0] aa, input logic [31:0] bb);
        set_op(op, f, o, aa, bb);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic exp_ovf;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_op(2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
        tick(2);
        check("rst_result", result, 32'd0);
        check("rst_zero", zero, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick(1);

        issue(2'b10, 6'b100010, 6'd0, 32'd5, 32'd5);
        check("sub_result", result, 32'd0);
        check("sub_zero", zero, 1'b1);
        check("sub_done", done, 1'b1);
        check("sub_illegal", illegal, 1'b0);

        issue(2'b11, 6'd0, 6'b001101, 32'h0000F0F0, 32'h00000F0F);
        check("ori_result", result, 32'h0000FFFF);
        check("ori_zero", zero, 1'b0);
        issue(2'b10, 6'b100111, 6'd0, 32'h0000F0F0, 32'h00000F0F);
        check("nor_result", result, 32'hFFFF0000);
        tick(1);
        check("idle_done", done, 1'b0);

        // back-to-back starts
        set_op(2'b00, 6'd0, 6'd0, 32'd1, 32'd2);
        start = 1'b1;
        tick(1);
        check("b2b_add", result, 32'd3);
        check("b2b_done1", done, 1'b1);
        set_op(2'b10, 6'b101010, 6'd0, 32'hFFFFFFFF, 32'd1);
        tick(1);
        start = 1'b0;
        check("b2b_slt", result, 32'd1);
        check("b2b_done2", done, 1'b1);

        // signed multiply -3 * 7, with mfhi pending through FIN
        issue(2'b10, 6'b011000, 6'd0, 32'hFFFFFFFD, 32'd7);
        check("mult_busy0", busy, 1'b1);
        check("mult_done0", done, 1'b0);
        check("mult_hold", result, 32'd1);
        tick(32);
        check("mult_busy32", busy, 1'b1);
        check("mult_done32", done, 1'b0);
        set_op(2'b10, 6'b010000, 6'd0, 32'd0, 32'd0);
        start = 1'b1;
        tick(1);
        check("mult_done33", done, 1'b1);
        check("mult_busy33", busy, 1'b0);
        check("mult_fin_mfhi_ignored", result, 32'd1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        tick(1);
        start = 1'b0;
        check("mfhi_result", result, 32'hFFFFFFFF);
        check("mfhi_done", done, 1'b1);
        tick(1);
        check("mfhi_done_drop", done, 1'b0);

        // unsigned multiply with an ignored start at cycle 10
        issue(2'b10, 6'b011001, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick(9);
        set_op(2'b00, 6'd0, 6'd0, 32'd1, 32'd1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("multu_ign_result", result, 32'hFFFFFFFF);
        check("multu_ign_busy", busy, 1'b1);
        check("multu_ign_done", done, 1'b0);
        tick(23);
        check("multu_done", done, 1'b1);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);
        tick(1);
        check("multu_done_drop", done, 1'b0);
        check("multu_busy_drop", busy, 1'b0);
        issue(2'b10, 6'b010010, 6'd0, 32'd0, 32'd0);
        check("mflo_result", result, 32'h00000001);

        // most-negative squared
        issue(2'b10, 6'b011000, 6'd0, 32'h80000000, 32'h80000000);
        tick(33);
        check("mneg_done", done, 1'b1);
        check("mneg_hi", hi, 32'h40000000);
        check("mneg_lo", lo, 32'h00000000);

        // wrap-around sub
        issue(2'b01, 6'd0, 6'd0, 32'd0, 32'd1);
        check("sub_wrap", result, 32'hFFFFFFFF);

        // signed overflow
`ifdef ALU_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        issue(2'b10, 6'b100000, 6'd0, 32'h7FFFFFFF, 32'd1);
        check("ovf_result", result, 32'h80000000);
        check("ovf_flag", ovf, exp_ovf);
        issue(2'b00, 6'd0, 6'd0, 32'd1, 32'd1);
        check("noovf_flag", ovf, 1'b0);

        // illegal funct
        issue(2'b10, 6'b111111, 6'd0, 32'd5, 32'd5);
        check("ill_flag", illegal, 1'b1);
        check("ill_result", result, 32'd0);
        check("ill_done", done, 1'b1);
        issue(2'b11, 6'd0, 6'b000000, 32'd5, 32'd5);
        check("ill_opcode", illegal, 1'b1);

        // reset in the middle of a multiply
        issue(2'b10, 6'b011000, 6'd0, 32'd3, 32'd4);
        tick(4);
        reset = 1'b1;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        check("rstmid_zero", zero, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        tick(1);
        check("rstmid_idle", busy, 1'b0);
        issue(2'b00, 6'd0, 6'd0, 32'd2, 32'd3);
        check("post_rst_add", result, 32'd5);
        check("post_rst_hi", hi, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
